// File: rtl/seg7_hex_history_scan.sv
// Multi-digit hex display: keeps the last NUM_BYTES received bytes and scans them onto a shared 7-segment bus.
// Optional build macro SEG7_DP_ACTIVITY_EN lights the decimal point on digit 0 while activity is high.
module seg7_hex_history_scan #(
  parameter int CLK_FREQ         = 25000000,
  parameter int NUM_BYTES        = 2,
  parameter int SCAN_HZ          = 1000,
  parameter int BLANK_CYCLES     = 16,
  parameter int SEG_ACTIVE_LOW   = 1,
  parameter int DIGIT_ACTIVE_LOW = 0,
  parameter int IDLE_SHIFT       = 24,
  parameter int ACT_STRETCH      = 1250000
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [7:0]             data_in,
  input  logic                   data_valid,
  input  logic                   clear,
  output logic [6:0]             seg,
  output logic                   seg_dp,
  output logic [2*NUM_BYTES-1:0] digit_sel,
  output logic [7:0]             byte_count,
  output logic                   activity
);

  localparam int ND       = 2 * NUM_BYTES;
  localparam int HW       = 8 * NUM_BYTES;
  localparam int SCAN_DIV = CLK_FREQ / SCAN_HZ;
  localparam int PW       = $clog2(SCAN_DIV);
  localparam int IW       = $clog2(ND);
  localparam int TW       = $clog2(ACT_STRETCH + 1);
  localparam int IDW      = IDLE_SHIFT + 4;

  localparam logic          SEG_INV = (SEG_ACTIVE_LOW != 0);
  localparam logic          DIG_INV = (DIGIT_ACTIVE_LOW != 0);
  localparam logic [6:0]    SEG_OFF = {7{SEG_INV}};
  localparam logic [ND-1:0] DIG_OFF = {ND{DIG_INV}};

  logic [HW-1:0]        hist_q, hist_d;
  logic [NUM_BYTES-1:0] mask_q, mask_d;
  logic [7:0]           cnt_q, cnt_d;
  logic [PW-1:0]        presc_q, presc_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic [IDW-1:0]       idle_q, idle_d;
  logic [TW-1:0]        timer_q, timer_d;
  logic [6:0]           seg_q, seg_d;
  logic [ND-1:0]        digit_sel_q, digit_sel_d;

  logic [7:0] cur_byte;
  logic       cur_written;
  logic [3:0] cur_nib;
  logic [6:0] lit;
  logic       blank;

  function automatic logic [6:0] hex_glyph(input logic [3:0] n);
    case (n)
      4'h0: hex_glyph = 7'h3F;
      4'h1: hex_glyph = 7'h06;
      4'h2: hex_glyph = 7'h5B;
      4'h3: hex_glyph = 7'h4F;
      4'h4: hex_glyph = 7'h66;
      4'h5: hex_glyph = 7'h6D;
      4'h6: hex_glyph = 7'h7D;
      4'h7: hex_glyph = 7'h07;
      4'h8: hex_glyph = 7'h7F;
      4'h9: hex_glyph = 7'h6F;
      4'hA: hex_glyph = 7'h77;
      4'hB: hex_glyph = 7'h7C;
      4'hC: hex_glyph = 7'h39;
      4'hD: hex_glyph = 7'h5E;
      4'hE: hex_glyph = 7'h79;
      default: hex_glyph = 7'h71;
    endcase
  endfunction

  // Clear takes effect first so a same-cycle byte lands in an empty history.
  always_comb begin
    hist_d  = clear ? '0 : hist_q;
    mask_d  = clear ? '0 : mask_q;
    cnt_d   = clear ? '0 : cnt_q;
    timer_d = timer_q;
    if (data_valid) begin
      hist_d  = (hist_d << 8) | HW'(data_in);
      mask_d  = (mask_d << 1) | NUM_BYTES'(1);
      timer_d = TW'(ACT_STRETCH);
      if (cnt_d != 8'hFF) cnt_d = cnt_d + 8'd1;
    end else if (timer_q != '0) begin
      timer_d = timer_q - TW'(1);
    end
    idle_d  = idle_q + IDW'(1);
    presc_d = presc_q + PW'(1);
    idx_d   = idx_q;
    if (presc_q == PW'(SCAN_DIV - 1)) begin
      presc_d = '0;
      idx_d   = (idx_q == IW'(ND - 1)) ? '0 : idx_q + IW'(1);
    end
  end

  always_comb begin
    cur_byte    = 8'h00;
    cur_written = 1'b0;
    for (int k = 0; k < NUM_BYTES; k++) begin
      if (int'(idx_q) / 2 == k) begin
        cur_byte    = hist_q[k*8 +: 8];
        cur_written = mask_q[k];
      end
    end
    cur_nib = idx_q[0] ? cur_byte[7:4] : cur_byte[3:0];
    if (mask_q == '0)     lit = hex_glyph(idle_q[IDLE_SHIFT +: 4]);
    else if (cur_written) lit = hex_glyph(cur_nib);
    else                  lit = 7'h00;
    seg_d = lit ^ SEG_OFF;
    blank = (presc_q < PW'(BLANK_CYCLES));
    digit_sel_d = DIG_OFF;
    for (int k = 0; k < ND; k++) begin
      if (!blank && int'(idx_q) == k) digit_sel_d[k] = ~DIG_INV;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist_q      <= '0;
      mask_q      <= '0;
      cnt_q       <= '0;
      presc_q     <= '0;
      idx_q       <= '0;
      idle_q      <= '0;
      timer_q     <= '0;
      seg_q       <= SEG_OFF;
      digit_sel_q <= DIG_OFF;
    end else begin
      hist_q      <= hist_d;
      mask_q      <= mask_d;
      cnt_q       <= cnt_d;
      presc_q     <= presc_d;
      idx_q       <= idx_d;
      idle_q      <= idle_d;
      timer_q     <= timer_d;
      seg_q       <= seg_d;
      digit_sel_q <= digit_sel_d;
    end
  end

`ifdef SEG7_DP_ACTIVITY_EN
  logic seg_dp_q, seg_dp_d;

  always_comb begin
    seg_dp_d = SEG_INV;
    if (timer_q != '0 && idx_q == '0 && !blank) seg_dp_d = ~SEG_INV;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) seg_dp_q <= SEG_INV;
    else        seg_dp_q <= seg_dp_d;
  end

  assign seg_dp = seg_dp_q;
`else
  assign seg_dp = SEG_INV;
`endif

  assign seg        = seg_q;
  assign digit_sel  = digit_sel_q;
  assign byte_count = cnt_q;
  assign activity   = (timer_q != '0);

endmodule

// File: tb/tb_seg7_hex_history_scan.sv
// Directed bench for seg7_hex_history_scan: 4 digits, 10-clock slots, 2 blank clocks, idle nibble from counter bits [7:4].
module tb_seg7_hex_history_scan;

  localparam int ACT = 20;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] data_in;
  logic       data_valid;
  logic       clear;
  logic [6:0] seg;
  logic       seg_dp;
  logic [3:0] digit_sel;
  logic [7:0] byte_count;
  logic       activity;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc;

  // Active-low glyphs 0..F (bit0 = a).
  logic [6:0] glyph_al [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  seg7_hex_history_scan #(
    .CLK_FREQ(1000), .NUM_BYTES(2), .SCAN_HZ(100), .BLANK_CYCLES(2),
    .SEG_ACTIVE_LOW(1), .DIGIT_ACTIVE_LOW(0), .IDLE_SHIFT(4), .ACT_STRETCH(ACT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .data_in(data_in), .data_valid(data_valid), .clear(clear),
    .seg(seg), .seg_dp(seg_dp), .digit_sel(digit_sel), .byte_count(byte_count),
    .activity(activity)
  );

  always #5 clk = ~clk;

  // Clocks since reset release; equals the DUT idle counter after each edge.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_digit(input int d);
    int n = 0;
    while (digit_sel !== 4'(1 << d) && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (n >= 60) chk("wait_digit", digit_sel, 4'(1 << d));
  endtask

  task automatic send_byte(input logic [7:0] b);
    data_in    = b;
    data_valid = 1'b1;
    @(negedge clk);
    data_valid = 1'b0;
  endtask

  task automatic check_digits(input string tag, input logic [6:0] d3, input logic [6:0] d2,
                              input logic [6:0] d1, input logic [6:0] d0);
    wait_digit(0); chk({tag, "_d0"}, seg, d0);
    wait_digit(1); chk({tag, "_d1"}, seg, d1);
    wait_digit(2); chk({tag, "_d2"}, seg, d2);
    wait_digit(3); chk({tag, "_d3"}, seg, d3);
  endtask

  task automatic act_len(input string tag, input int exp);
    int n = 0;
    while (activity && n < 100) begin
      n++;
      @(negedge clk);
    end
    chk(tag, n, exp);
  endtask

  task automatic check_idle(input string tag);
    for (int d = 0; d < 4; d++) begin
      wait_digit(d);
      chk(tag, seg, glyph_al[((cyc - 1) & 255) >> 4]);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; data_in = 8'h00; data_valid = 1'b0; clear = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_sel", digit_sel, 4'b0000);
    chk("rst_seg", seg, 7'h7F);
    chk("rst_dp", seg_dp, 1'b1);
    chk("rst_cnt", byte_count, 8'd0);
    chk("rst_act", activity, 1'b0);

    // Idle scan: after edge k the slot is (k-1)/10, first two clocks blank.
    rst_n = 1'b1;
    for (int k = 1; k <= 42; k++) begin
      @(negedge clk);
      chk("scan_sel", digit_sel, ((k - 1) % 10 < 2) ? 4'b0000 : 4'(1 << (((k - 1) / 10) % 4)));
      chk("scan_idle", seg, glyph_al[((k - 1) >> 4) & 15]);
    end

    send_byte(8'h4B);
    chk("b1_cnt", byte_count, 8'd1);
    act_len("b1_act_len", ACT);
    check_digits("b1", 7'h7F, 7'h7F, glyph_al[4], glyph_al[11]);
    wait_digit(0);
    chk("b1_dp", seg_dp, 1'b1);

    send_byte(8'h12);
    send_byte(8'h34);
    send_byte(8'h56);
    repeat (2) @(negedge clk);
    chk("sh_cnt", byte_count, 8'd4);
    check_digits("sh", glyph_al[3], glyph_al[4], glyph_al[5], glyph_al[6]);

    data_valid = 1'b1;
    for (int i = 0; i < 300; i++) begin
      data_in = i[7:0];
      @(negedge clk);
    end
    data_valid = 1'b0;
    chk("sat_cnt", byte_count, 8'd255);
    repeat (2) @(negedge clk);
    wait_digit(0);
    chk("sat_d0", seg, glyph_al[11]);

    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    chk("clr_cnt", byte_count, 8'd0);
    repeat (2) @(negedge clk);
    check_idle("clr_idle");

    clear = 1'b1; data_in = 8'hA7; data_valid = 1'b1;
    @(negedge clk);
    clear = 1'b0; data_valid = 1'b0;
    chk("cv_cnt", byte_count, 8'd1);
    repeat (2) @(negedge clk);
    check_digits("cv", 7'h7F, 7'h7F, glyph_al[10], glyph_al[7]);

    // Second pulse half-way through the first stretch restarts the full length.
    repeat (ACT + 5) @(negedge clk);
    send_byte(8'h00);
    repeat (ACT / 2 - 1) @(negedge clk);
    chk("rt_mid", activity, 1'b1);
    send_byte(8'h01);
    act_len("rt_act_len", ACT);

    wait_digit(1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_sel", digit_sel, 4'b0000);
    chk("arst_seg", seg, 7'h7F);
    chk("arst_cnt", byte_count, 8'd0);
    chk("arst_act", activity, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
